// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, receive FSM states and player key codes
// used by both the frame receiver and the downstream key decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_CHECK
   } ps2_state_e;

   localparam logic [7:0] KEY_1D = 8'h1D;
   localparam logic [7:0] KEY_1B = 8'h1B;
   localparam logic [7:0] KEY_1C = 8'h1C;
   localparam logic [7:0] KEY_23 = 8'h23;
   localparam logic [7:0] KEY_29 = 8'h29;
   localparam logic [7:0] KEY_43 = 8'h43;
   localparam logic [7:0] KEY_42 = 8'h42;
   localparam logic [7:0] KEY_3B = 8'h3B;
   localparam logic [7:0] KEY_4B = 8'h4B;
   localparam logic [7:0] KEY_5A = 8'h5A;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, level-stability filter and falling-edge detector for
// the raw PS/2 clock pin.
module ps2_sync_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk_50m,
   input  logic rst,
   input  logic din,
   output logic fall
);

   localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

   logic          meta_q, sync_q;
   logic          filt_q, filt_d;
   logic          filt_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // The filtered level flips on the FILTER_LEN-th consecutive differing cycle.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         meta_q     <= 1'b1;
         sync_q     <= 1'b1;
         filt_q     <= 1'b1;
         filt_dly_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         meta_q     <= din;
         sync_q     <= meta_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign fall = filt_dly_q & ~filt_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: recovers scan-code bytes and folds E0/F0 prefixes into flags.
// Define PS2_PARITY_CHECK_EN to reject frames with an odd-parity mismatch.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       kclk,
   input  logic       kdata,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic          fall;
   logic          kd_meta_q, kd_sync_q;
   logic          frame_ok;
   ps2_state_e    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          pend_brk_q, pend_brk_d;
   logic          pend_ext_q, pend_ext_d;
   logic [7:0]    scan_code_q, scan_code_d;
   logic          code_valid_q, code_valid_d;
   logic          is_break_q, is_break_d;
   logic          is_ext_q, is_ext_d;
   logic          frame_err_q, frame_err_d;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
      .clk_50m (clk_50m),
      .rst     (rst),
      .din     (kclk),
      .fall    (fall)
   );

   // shift_q after ten falls: [7:0] data, [8] parity, [9] stop
`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = shift_q[9] & (^shift_q[8:0]);
`else
   logic parity_unused;
   assign parity_unused = shift_q[8];
   assign frame_ok      = shift_q[9];
`endif

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tmo_d        = '0;
      pend_brk_d   = pend_brk_q;
      pend_ext_d   = pend_ext_q;
      scan_code_d  = scan_code_q;
      code_valid_d = 1'b0;
      is_break_d   = is_break_q;
      is_ext_d     = is_ext_q;
      frame_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall && !kd_sync_q) begin
               state_d   = ST_RECV;
               bit_cnt_d = 4'd1;
            end
         end
         ST_RECV: begin
            if (fall) begin
               shift_d = {kd_sync_q, shift_q[9:1]};
               if (bit_cnt_q == 4'd10) begin
                  state_d = ST_CHECK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               frame_err_d = 1'b1;
               state_d     = ST_IDLE;
               bit_cnt_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_CHECK: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            if (!frame_ok) begin
               frame_err_d = 1'b1;
               pend_brk_d  = 1'b0;
               pend_ext_d  = 1'b0;
            end else if (shift_q[7:0] == PS2_BREAK) begin
               pend_brk_d = 1'b1;
            end else if (shift_q[7:0] == PS2_EXT) begin
               pend_ext_d = 1'b1;
            end else begin
               scan_code_d  = shift_q[7:0];
               is_break_d   = pend_brk_q;
               is_ext_d     = pend_ext_q;
               code_valid_d = 1'b1;
               pend_brk_d   = 1'b0;
               pend_ext_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         kd_meta_q    <= 1'b1;
         kd_sync_q    <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tmo_q        <= '0;
         pend_brk_q   <= 1'b0;
         pend_ext_q   <= 1'b0;
         scan_code_q  <= '0;
         code_valid_q <= 1'b0;
         is_break_q   <= 1'b0;
         is_ext_q     <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         kd_meta_q    <= kdata;
         kd_sync_q    <= kd_meta_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tmo_q        <= tmo_d;
         pend_brk_q   <= pend_brk_d;
         pend_ext_q   <= pend_ext_d;
         scan_code_q  <= scan_code_d;
         code_valid_q <= code_valid_d;
         is_break_q   <= is_break_d;
         is_ext_q     <= is_ext_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign scan_code   = scan_code_q;
   assign code_valid  = code_valid_q;
   assign is_break    = is_break_q;
   assign is_extended = is_ext_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame; kclk runs faster than a real keyboard and the
// timeout is shortened so the whole run stays small.
module tb_ps2_rx_frame;

   localparam int unsigned FLT  = 8;
   localparam int unsigned TMO  = 2000;
   localparam int unsigned HALF = 40;

   logic       clk_50m = 1'b0;
   logic       rst     = 1'b1;
   logic       kclk    = 1'b1;
   logic       kdata   = 1'b1;
   logic [7:0] scan_code;
   logic       code_valid, is_break, is_extended, frame_err;

   always #10 clk_50m = ~clk_50m;

   ps2_rx_frame #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
      .clk_50m     (clk_50m),
      .rst         (rst),
      .kclk        (kclk),
      .kdata       (kdata),
      .scan_code   (scan_code),
      .code_valid  (code_valid),
      .is_break    (is_break),
      .is_extended (is_extended),
      .frame_err   (frame_err)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   logic m_brk = 1'b0;
   logic m_ext = 1'b0;

   // Every strobe is matched against the oldest expected event.
   always @(negedge clk_50m) begin
      if (!rst && (code_valid || frame_err)) begin
         tests++;
         if (code_valid && frame_err) begin
            fails++;
            $display("FAIL excl: code_valid=%b frame_err=%b, required not both high", code_valid, frame_err);
         end
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected: code_valid=%b frame_err=%b scan_code=%h, required no strobe",
                     code_valid, frame_err, scan_code);
         end else begin
            e = sb.pop_front();
            tests++;
            if (frame_err !== e.err || code_valid !== !e.err) begin
               fails++;
               $display("FAIL kind: frame_err=%b code_valid=%b, required frame_err=%b", frame_err, code_valid, e.err);
            end
            if (!e.err) begin
               tests++;
               if (scan_code !== e.code) begin
                  fails++;
                  $display("FAIL scan_code: got %h, required %h", scan_code, e.code);
               end
               tests++;
               if (is_break !== e.brk) begin
                  fails++;
                  $display("FAIL is_break: got %b, required %b (code %h)", is_break, e.brk, e.code);
               end
               tests++;
               if (is_extended !== e.ext) begin
                  fails++;
                  $display("FAIL is_extended: got %b, required %b (code %h)", is_extended, e.ext, e.code);
               end
            end
         end
      end
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip, input bit stop);
      logic p;
      p = (~^b) ^ flip;
      return {stop, p, b, 1'b0};
   endfunction

   // Glitches of FLT-1 cycles land mid-phase, clear of both kclk edges.
   task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         kdata = bits[i];
         if (glitch) begin
            clk_wait(15); kclk = 1'b0; clk_wait(FLT - 1); kclk = 1'b1; clk_wait(HALF - 15 - (FLT - 1));
         end else begin
            clk_wait(HALF);
         end
         kclk = 1'b0;
         if (glitch) begin
            clk_wait(15); kclk = 1'b1; clk_wait(FLT - 1); kclk = 1'b0; clk_wait(HALF - 15 - (FLT - 1));
         end else begin
            clk_wait(HALF);
         end
         kclk = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit flip, input bit stop, input bit glitch);
      bit bad;
      bad = !stop;
`ifdef PS2_PARITY_CHECK_EN
      bad = bad | flip;
`endif
      if (bad) begin
         sb.push_back('{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0});
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else begin
         sb.push_back('{err: 1'b0, code: b, brk: m_brk, ext: m_ext});
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
      send_bits(mk_frame(b, flip, stop), 11, glitch);
      kdata = 1'b1;
      clk_wait(100);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 500) begin
         clk_wait(1);
         k++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s drain: %0d expected strobes missing, required 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clk_wait(5);
      tests += 5;
      if (scan_code !== 8'h00) begin fails++; $display("FAIL rst scan_code: got %h, required 00", scan_code); end
      if (code_valid !== 1'b0) begin fails++; $display("FAIL rst code_valid: got %b, required 0", code_valid); end
      if (is_break !== 1'b0) begin fails++; $display("FAIL rst is_break: got %b, required 0", is_break); end
      if (is_extended !== 1'b0) begin fails++; $display("FAIL rst is_extended: got %b, required 0", is_extended); end
      if (frame_err !== 1'b0) begin fails++; $display("FAIL rst frame_err: got %b, required 0", frame_err); end
      rst = 1'b0;
      clk_wait(50);
   endtask

   task automatic test_single;
      send_byte(8'h1D, 1'b0, 1'b1, 1'b0);
      drain("single");
   endtask

   task automatic test_break;
      send_byte(8'hF0, 1'b0, 1'b1, 1'b0);
      send_byte(8'h1D, 1'b0, 1'b1, 1'b0);
      send_byte(8'h1D, 1'b0, 1'b1, 1'b0);
      drain("break");
   endtask

   task automatic test_extended;
      send_byte(8'hE0, 1'b0, 1'b1, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b1, 1'b0);
      send_byte(8'h75, 1'b0, 1'b1, 1'b0);
      send_byte(8'h5A, 1'b0, 1'b1, 1'b0);
      drain("extended");
   endtask

   task automatic test_parity;
      send_byte(8'h29, 1'b1, 1'b1, 1'b0);
      drain("parity");
   endtask

   task automatic test_stop_timeout;
      send_byte(8'h33, 1'b0, 1'b0, 1'b0);
      drain("stop");
      sb.push_back('{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0});
      send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5, 1'b0);
      kdata = 1'b1;
      clk_wait(TMO + 200);
      drain("timeout");
      send_byte(8'h42, 1'b0, 1'b1, 1'b0);
      drain("after_timeout");
   endtask

   task automatic test_glitch_reset;
      send_byte(8'hF0, 1'b0, 1'b1, 1'b1);
      send_bits(mk_frame(8'h1D, 1'b0, 1'b1), 5, 1'b1);
      clk_wait(10);
      rst = 1'b1;
      clk_wait(1);
      rst = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      kdata = 1'b1;
      clk_wait(2);
      tests += 5;
      if (scan_code !== 8'h00) begin fails++; $display("FAIL midrst scan_code: got %h, required 00", scan_code); end
      if (code_valid !== 1'b0) begin fails++; $display("FAIL midrst code_valid: got %b, required 0", code_valid); end
      if (is_break !== 1'b0) begin fails++; $display("FAIL midrst is_break: got %b, required 0", is_break); end
      if (is_extended !== 1'b0) begin fails++; $display("FAIL midrst is_extended: got %b, required 0", is_extended); end
      if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst frame_err: got %b, required 0", frame_err); end
      clk_wait(200);
      send_byte(8'h4B, 1'b0, 1'b1, 1'b1);
      drain("glitch_reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_break();
      test_extended();
      test_parity();
      test_stop_timeout();
      test_glitch_reset();
      clk_wait(50);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: run exceeded its time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
